nv_cdc_hs_arb_src: RTL
======================

// Module: nv_cdc_hs_arb_src
// PURPOSE
//  Source-domain arbiter and 4-phase handshake sequencer for one shared CDC channel.
//  NREQ requesters share one request bit, which crosses into the destination domain
//  through a strict 3-stage sync cell, and one DW-bit payload bus held quasi-static.
//  The destination returns an ack bit, already resynchronised into SRC_CLK, on hs_ack.
//  The block arbitrates round-robin, holds the payload stable and sequences req/ack.
// PARAMETERS
//  NREQ   4  number of requesters (2..8)
//  DW     8  payload width per requester
//  IDW    2  requester-id width; must equal clog2(NREQ)
//  TO_W   8  timeout counter width; timeout fires at 2^TO_W-1 wait cycles
// PORTS
//  SRC_CLK      in   1        source clock
//  SRC_CLRN     in   1        async active-low reset, SRC_CLK domain
//  req_vld      in   NREQ     per-requester transfer request, level, held until req_rdy
//  req_pd       in   NREQ*DW  per-requester payload; slice i = req_pd[i*DW +: DW]
//  req_rdy      out  NREQ     one-hot accept pulse (combinational), 1 cycle
//  hs_req_next  out  1        registered; drives SRC_D_NEXT of the strict sync cell
//  hs_req_q     in   1        SRC_D of the sync cell (registered copy of hs_req_next)
//  hs_ack       in   1        destination ack, already synchronised to SRC_CLK
//  xfer_pd      out  DW       registered payload to destination, quasi-static
//  xfer_id      out  IDW      registered id of the granted requester
//  busy         out  1        1 when state != IDLE
//  timeout_err  out  1        sticky handshake-timeout flag
//  err_clr      in   1        clears timeout_err
// BEHAVIOUR
//  Reset (SRC_CLRN low, async): state=IDLE, hs_req_next=0, xfer_pd=0, xfer_id=0,
//   timeout_err=0, wait counter=0, rr pointer=0 (req0 highest priority first).
//   Reset mid-transfer aborts immediately. No recovery is attempted; the dst side is reset too.
//  States: IDLE -> SET -> CLR -> IDLE.
//  IDLE: arbitrate only if |req_vld && hs_req_q==0 && hs_ack==0 (stale ack blocks).
//   Grant g = first set req_vld at or after ptr, wrapping mod NREQ.
//   Cycle t: req_rdy[g]=1. Cycle t+1: xfer_pd=req_pd[g], xfer_id=g, hs_req_next=1,
//   ptr=(g+1) mod NREQ, state=SET.
//  SET: hs_req_next=1. Go to CLR when hs_req_q==1 && hs_ack==1; hs_req_next=0 from the next cycle.
//  CLR: hs_req_next=0. Go to IDLE when hs_req_q==0 && hs_ack==0.
//   The earliest new grant comes the cycle after IDLE is entered.
//  req_rdy=0 outside IDLE. xfer_pd/xfer_id are held constant from SET entry until the next grant.
//  Timeout: the counter clears on entering SET or CLR and increments each cycle spent in them,
//   saturating. On reaching 2^TO_W-1 it sets timeout_err. The FSM keeps waiting (no abort).
//  err_clr clears timeout_err; if set and clear coincide, set wins.
//  A requester dropping req_vld before its grant is legal; it is simply not granted.
//  Minimum transfer: 1 grant cycle plus the round-trip latency of the sync cells.
// TESTING
//  1 req_vld=4'b0010, pd1=8'hA5, ack follows req after 4 cycles -> req_rdy=0010 once,
//    xfer_pd=A5, xfer_id=1, hs_req_next 1 then 0, back in IDLE, busy low.
//  2 req_vld=4'b1111 held for 4 transfers -> grant order 0,1,2,3; 5th grant goes to 0 again.
//  3 After a grant to 2, req_vld=4'b0101 -> next grant 0 (wrap), then 2.
//  4 hs_ack stuck 0 in SET for 255 cycles (TO_W=8) -> timeout_err=1, hs_req_next stays 1;
//    err_clr pulse -> 0; release ack -> completes normally.
//  5 hs_ack=1 while IDLE with req_vld=0001 -> no req_rdy until ack falls, then grant 0.
//  6 SRC_CLRN low during SET -> hs_req_next, busy, xfer_pd=0 async; ptr=0 after release.

Source files
------------

// File: rtl/nv_cdc_hs_arb_src.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | nv_cdc_hs_arb_src: round-robin arbiter + 4-phase req/ack sequencer (src)   |
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+
module nv_cdc_hs_arb_src #(
  parameter int NREQ = 4,
  parameter int DW   = 8,
  parameter int IDW  = 2,
  parameter int TO_W = 8
) (
  input  logic               SRC_CLK,
  input  logic               SRC_CLRN,
  input  logic [NREQ-1:0]    req_vld,
  input  logic [NREQ*DW-1:0] req_pd,
  output logic [NREQ-1:0]    req_rdy,
  output logic               hs_req_next,
  input  logic               hs_req_q,
  input  logic               hs_ack,
  output logic [DW-1:0]      xfer_pd,
  output logic [IDW-1:0]     xfer_id,
  output logic               busy,
  output logic               timeout_err,
  input  logic               err_clr
);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_SET  = 2'd1,
    ST_CLR  = 2'd2
  } state_t;

  localparam logic [TO_W-1:0] CNT_MAX = {TO_W{1'b1}};

  state_t            state_q, state_d;
  logic              req_out_q, req_out_d;
  logic [DW-1:0]     pd_q, pd_d;
  logic [IDW-1:0]    id_q, id_d;
  logic [IDW-1:0]    ptr_q, ptr_d;
  logic [TO_W-1:0]   cnt_q, cnt_d, cnt_inc;
  logic              err_q, err_d, err_set;
  logic              grant_found;
  logic [IDW-1:0]    grant_idx;
  logic              grant;

  // Search starting at the round-robin pointer, wrapping modulo NREQ.
  always_comb begin
    logic [IDW:0] sum;
    sum         = '0;
    grant_found = 1'b0;
    grant_idx   = '0;
    for (int k = 0; k < NREQ; k++) begin
      sum = {1'b0, ptr_q} + (IDW+1)'(k);
      if (sum >= (IDW+1)'(NREQ)) sum = sum - (IDW+1)'(NREQ);
      if (!grant_found && req_vld[sum[IDW-1:0]]) begin
        grant_found = 1'b1;
        grant_idx   = sum[IDW-1:0];
      end
    end
  end

  // A stale ack or un-returned request from the previous transfer blocks arbitration.
  assign grant   = (state_q == ST_IDLE) && grant_found && !hs_req_q && !hs_ack;
  assign req_rdy = grant ? (NREQ'(1) << grant_idx) : '0;
  assign cnt_inc = (cnt_q == CNT_MAX) ? cnt_q : cnt_q + TO_W'(1);

  always_comb begin
    state_d   = state_q;
    req_out_d = req_out_q;
    pd_d      = pd_q;
    id_d      = id_q;
    ptr_d     = ptr_q;
    cnt_d     = cnt_q;
    case (state_q)
      ST_IDLE: begin
        if (grant) begin
          state_d   = ST_SET;
          req_out_d = 1'b1;
          pd_d      = req_pd[grant_idx*DW +: DW];
          id_d      = grant_idx;
          ptr_d     = (grant_idx == IDW'(NREQ-1)) ? '0 : grant_idx + IDW'(1);
          cnt_d     = '0;
        end
      end
      ST_SET: begin
        req_out_d = 1'b1;
        if (hs_req_q && hs_ack) begin
          state_d   = ST_CLR;
          req_out_d = 1'b0;
          cnt_d     = '0;
        end else begin
          cnt_d = cnt_inc;
        end
      end
      ST_CLR: begin
        req_out_d = 1'b0;
        cnt_d     = cnt_inc;
        if (!hs_req_q && !hs_ack) state_d = ST_IDLE;
      end
      default: begin
        state_d   = ST_IDLE;
        req_out_d = 1'b0;
      end
    endcase
  end

  // Flag only on the transition into saturation so a clear sticks while still waiting.
  assign err_set = (state_q != ST_IDLE) && (cnt_q != CNT_MAX) && (cnt_d == CNT_MAX);
  assign err_d   = err_set ? 1'b1 : (err_clr ? 1'b0 : err_q);

  always_ff @(posedge SRC_CLK or negedge SRC_CLRN) begin
    if (!SRC_CLRN) begin
      state_q   <= ST_IDLE;
      req_out_q <= 1'b0;
      pd_q      <= '0;
      id_q      <= '0;
      ptr_q     <= '0;
      cnt_q     <= '0;
      err_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      req_out_q <= req_out_d;
      pd_q      <= pd_d;
      id_q      <= id_d;
      ptr_q     <= ptr_d;
      cnt_q     <= cnt_d;
      err_q     <= err_d;
    end
  end

  assign hs_req_next = req_out_q;
  assign xfer_pd     = pd_q;
  assign xfer_id     = id_q;
  assign busy        = (state_q != ST_IDLE);
  assign timeout_err = err_q;

endmodule
`default_nettype wire
